acumulador_multicanal: RTL

ACUMULADOR_MULTICANAL -- requirements
Module: acumulador_multicanal

---
 rtl/acumulador_multicanal.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/acumulador_multicanal.sv
// rtl/acumulador_multicanal.sv - two-stage multi-channel accumulator with wrap or saturation
//
// Purpose:
//   N_CH independent NB_ACC-bit accumulators sharing one two-stage pipeline.
//   Stage 1 registers the request and the full-width operand sum S.
//   Stage 2 reads, modifies and writes the addressed accumulator in the same
//   cycle, so consecutive operations on one channel see each other's results
//   with no stalls. Results appear exactly two cycles after i_valid.
//
// Ports:
//   i_clk        clock, rising-edge
//   i_rst        synchronous active-high reset
//   i_valid      request strobe qualifying i_ch, i_sel, i_data1, i_data2
//   i_ch         target channel
//   i_sel        00 accumulate, 01 decrement, 10 load, 11 clear
//   i_data1/2    unsigned operands, summed into S
//   o_valid      one-cycle result strobe
//   o_ch         channel of the reported result (held while o_valid low)
//   o_data       post-operation accumulator value (held while o_valid low)
//   o_overflow   carry/borrow of the reported operation
//   o_ovf_flags  per-channel sticky overflow flags

module acumulador_multicanal #(
    parameter int  NB_DATA  = 3,
    parameter int  NB_ACC   = 2 * NB_DATA,
    parameter int  N_CH     = 4,
    parameter int  SAT_MODE = 0,
    localparam int NB_CH    = $clog2(N_CH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_CH-1:0]   i_ch,
    input  logic [1:0]         i_sel,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic [NB_DATA-1:0] i_data2,
    output logic               o_valid,
    output logic [NB_CH-1:0]   o_ch,
    output logic [NB_ACC-1:0]  o_data,
    output logic               o_overflow,
    output logic [N_CH-1:0]    o_ovf_flags
);

    localparam int NB_SUM = NB_DATA + 1;

    typedef enum logic [1:0] {
        OP_ACC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // Stage 1 registers
    logic               s1_valid;
    logic [NB_CH-1:0]   s1_ch;
    op_e                s1_sel;
    logic [NB_SUM-1:0]  s1_sum;

    // Channel state
    logic [NB_ACC-1:0]  acc [N_CH];
    logic [N_CH-1:0]    ovf_flags;

    // Stage 2 combinational datapath
    logic [NB_ACC-1:0]  acc_cur;
    logic [NB_ACC:0]    sum_ext;
    logic [NB_ACC:0]    add_res;
    logic [NB_ACC:0]    sub_res;
    logic [NB_ACC-1:0]  acc_next;
    logic               op_ovf;
    logic               clr_flag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_sel   <= OP_ACC;
            s1_sum   <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_ch  <= i_ch;
                s1_sel <= op_e'(i_sel);
                s1_sum <= {1'b0, i_data1} + {1'b0, i_data2};
            end
        end
    end

    assign acc_cur = acc[s1_ch];
    assign sum_ext = {{(NB_ACC + 1 - NB_SUM){1'b0}}, s1_sum};
    assign add_res = {1'b0, acc_cur} + sum_ext;
    // Both operands are below 2^NB_ACC, so the extra MSB of the difference is the borrow.
    assign sub_res = {1'b0, acc_cur} - sum_ext;

    always_comb begin
        acc_next = acc_cur;
        op_ovf   = 1'b0;
        clr_flag = 1'b0;
        case (s1_sel)
            OP_ACC: begin
                op_ovf   = add_res[NB_ACC];
                acc_next = (SAT_MODE != 0 && op_ovf) ? {NB_ACC{1'b1}} : add_res[NB_ACC-1:0];
            end
            OP_DEC: begin
                op_ovf   = sub_res[NB_ACC];
                acc_next = (SAT_MODE != 0 && op_ovf) ? {NB_ACC{1'b0}} : sub_res[NB_ACC-1:0];
            end
            OP_LOAD: begin
                acc_next = sum_ext[NB_ACC-1:0];
            end
            OP_CLR: begin
                acc_next = '0;
                clr_flag = 1'b1;
            end
            default: begin
                acc_next = acc_cur;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
            end
            ovf_flags  <= '0;
            o_valid    <= 1'b0;
            o_ch       <= '0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_valid    <= s1_valid;
            o_overflow <= s1_valid & op_ovf;
            if (s1_valid) begin
                acc[s1_ch] <= acc_next;
                o_ch       <= s1_ch;
                o_data     <= acc_next;
                if (clr_flag) begin
                    ovf_flags[s1_ch] <= 1'b0;
                end else if (op_ovf) begin
                    ovf_flags[s1_ch] <= 1'b1;
                end
            end
        end
    end

    assign o_ovf_flags = ovf_flags;

endmodule
